// File: rtl/uart_rx_if.sv
// Register-bus port group for uart_rx: one-cycle access request and one-cycle completion.
// The slave side is the receiver; the master side is the bus host.
interface uart_rx_if;
   logic        uart_valid;
   logic [3:0]  uart_wstrb;
   logic [31:0] uart_rdata;
   logic        uart_ready;

   modport master (
      output uart_valid,
      output uart_wstrb,
      input  uart_rdata,
      input  uart_ready
   );

   modport slave (
      input  uart_valid,
      input  uart_wstrb,
      output uart_rdata,
      output uart_ready
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a receive FIFO and
// a single status/data register on a one-cycle request/ready bus.
module uart_rx #(
   parameter int CLK_DIVIDER = 868,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     rx,
   uart_rx_if.slave bus
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] HALF_LOAD = 16'(CLK_DIVIDER / 2 - 1);
   localparam logic [15:0] FULL_LOAD = 16'(CLK_DIVIDER - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // True when the eight data bits plus the parity bit hold an even number of ones.
   function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
      return ~(^data ^ par);
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   logic         r_rx_meta;
   logic         r_rx_sync;
   logic         r_rx_prev;
   logic         w_fall;

   state_t       r_state;
   logic [15:0]  r_cnt;
   logic [2:0]   r_bit_idx;
   logic [7:0]   r_shift;
   logic         r_push;
   logic [7:0]   r_push_data;
   logic         r_ferr_set;
   logic         w_perr_set;

   logic [7:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         r_ovf;
   logic         r_perr;
   logic         r_ferr;
   logic         r_ready;
   logic [31:0]  r_rdata;

   logic         w_empty;
   logic         w_full;
   logic         w_rd;
   logic         w_pop;
   logic         w_push_ok;
   logic         w_ovf_set;
   logic [7:0]   w_head;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_fall = r_rx_prev & ~r_rx_sync;

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;
   logic r_perr_set;
   assign w_perr_set = r_perr_set;
`else
   assign w_perr_set = 1'b0;
`endif

   // Frame FSM: half-bit wait to the start-bit centre, then one sample per bit period.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 16'd0;
         r_bit_idx   <= 3'd0;
         r_shift     <= 8'd0;
         r_push      <= 1'b0;
         r_push_data <= 8'd0;
         r_ferr_set  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad   <= 1'b0;
         r_perr_set  <= 1'b0;
`endif
      end else begin
         r_push     <= 1'b0;
         r_ferr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr_set <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state <= ST_START;
                  r_cnt   <= HALF_LOAD;
               end else begin
                  r_cnt   <= 16'd0;
               end
            end
            ST_START: begin
               if (r_cnt == 16'd0) begin
                  // A line that is high again at the start-bit centre was only a glitch.
                  if (!r_rx_sync) begin
                     r_state   <= ST_DATA;
                     r_cnt     <= FULL_LOAD;
                     r_bit_idx <= 3'd0;
                  end else begin
                     r_state   <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (r_cnt == 16'd0) begin
                  r_shift <= {r_rx_sync, r_shift[7:1]};
                  r_cnt   <= FULL_LOAD;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (r_cnt == 16'd0) begin
                  r_par_bad <= ~even_parity_ok(r_shift, r_rx_sync);
                  r_cnt     <= FULL_LOAD;
                  r_state   <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
`endif
            ST_STOP: begin
               if (r_cnt == 16'd0) begin
                  r_state <= ST_IDLE;
                  if (!r_rx_sync) begin
                     r_ferr_set <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (r_par_bad) begin
                     r_perr_set <= 1'b1;
`endif
                  end else begin
                     r_push      <= 1'b1;
                     r_push_data <= r_shift;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 16'd0;
            end
         endcase
      end
   end

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_rd      = bus.uart_valid && (bus.uart_wstrb == 4'd0);
   assign w_pop     = w_rd && !w_empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok = r_push && (!w_full || w_pop);
   assign w_ovf_set = r_push && w_full && !w_pop;
   assign w_head    = r_mem[r_rptr[AW-1:0]];

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (w_push_ok) begin
         r_mem[r_wptr[AW-1:0]] <= r_push_data;
      end else begin
         r_mem[r_wptr[AW-1:0]] <= r_mem[r_wptr[AW-1:0]];
      end
   end

   // Pointers, sticky error flags and the registered bus response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_ovf   <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ready <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end else begin
            r_rptr <= r_rptr;
         end
         r_ovf   <= w_ovf_set  | (r_ovf  & ~w_rd);
         r_perr  <= w_perr_set | (r_perr & ~w_rd);
         r_ferr  <= r_ferr_set | (r_ferr & ~w_rd);
         r_ready <= bus.uart_valid;
         if (w_rd) begin
            r_rdata <= {~w_empty, r_ovf, r_perr, r_ferr, 20'd0, (w_empty ? 8'd0 : w_head)};
         end else begin
            r_rdata <= 32'd0;
         end
      end
   end

   assign bus.uart_ready = r_ready;
   assign bus.uart_rdata = r_rdata;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIVIDER, default 868, clock cycles per bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clock, idle high.
REQ-006 SHALL have port uart_valid  input  1  bus access request, one-cycle pulse per access.
REQ-007 SHALL have port uart_wstrb  input  4  byte strobes; nonzero means write, zero means read.
REQ-008 SHALL have port uart_rdata  output  32  read data.
REQ-009 SHALL have port uart_ready  output  1  access completion, one-cycle pulse.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer, preset to 1; the FSM uses only the synchronized value.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 IDLE -> START on a synchronized 1->0 transition; bit counter loads CLK_DIVIDER/2 - 1 (integer division).
REQ-013 START: when counter reaches 0, sample line; 0 -> DATA, counter loads CLK_DIVIDER-1; 1 -> IDLE, glitch ignored, no flag set.
REQ-014 DATA: one sample per CLK_DIVIDER cycles at bit centre, 8 bits, LSB first; after bit 7 -> PARITY (macro) or STOP.
REQ-015 STOP: sample 1 -> push byte to FIFO, return to IDLE; sample 0 -> discard byte, set ferr, return to IDLE.
REQ-016 After STOP the FSM SHALL accept a new falling edge on the next cycle, with no extra idle time.
REQ-017 FIFO: circular, log2(FIFO_DEPTH)+1-bit read/write pointers, wrap at FIFO_DEPTH; full when MSBs differ and low bits match.
REQ-018 On a push while full with no pop in the same cycle, the byte SHALL be dropped, ovf set, and FIFO contents kept unchanged.
REQ-019 On a push and a pop in the same cycle, both SHALL take effect (no overflow, even when full); when empty, the pop is a no-op and the byte is stored.
REQ-020 uart_ready SHALL assert exactly one cycle after each uart_valid; latency 1, no wait states.
REQ-021 Read: uart_rdata = {nonempty, ovf, perr, ferr, 20'b0, head byte}, captured in the uart_valid cycle; pops if nonempty; clears ovf, perr, ferr.
REQ-022 Read while empty: bit 31 = 0, bits 7:0 = 0, no pop.
REQ-023 Write: SHALL assert uart_ready with uart_rdata = 0 and SHALL have no other effect.
REQ-024 Flag set and flag clear in the same cycle: set wins.
REQ-025 uart_rdata SHALL be 0 in every cycle that uart_ready is low.

Reset
REQ-026 On reset low: FSM IDLE, counters 0, pointers 0, FIFO empty, flags 0, synchronizer 1, uart_ready 0, uart_rdata 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, reception resumes only on a fresh falling edge.
REQ-028 FIFO storage contents need not be reset.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: 8E1 frame; PARITY state samples a ninth bit; on even-parity mismatch, byte discarded at STOP and perr set.
REQ-030 Macro UART_RX_PARITY_EN undefined: 8N1 frame; PARITY state and checker absent; bit 29 reads 0.

Verification (CLK_DIVIDER=16, FIFO_DEPTH=8)
REQ-031 Send 0x55 8N1, then read -> uart_ready one cycle after uart_valid, uart_rdata=0x8000_0055; second read -> 0x0000_0000.
REQ-032 Send 9 bytes 0x00..0x08 with no reads -> eight reads return 0x00..0x07 with bit 30 set on the first read only; ninth read -> 0x0000_0000.
REQ-033 Hold rx low for 4 cycles only -> no push, no flags; following frame 0xA3 read back as 0x8000_00A3.
REQ-034 Send 0x3C with stop bit 0 -> next read 0x1000_0000; subsequent 0x3C frame read as 0x8000_003C.
REQ-035 Assert reset during DATA bit 4 of a frame -> after release FIFO empty, read 0x0000_0000; next full frame 0x7E received intact.
REQ-036 With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> read 0x2000_0000; with parity bit 1 -> read 0x8000_0001.
